// File: rtl/ooo_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : ooo_read_responder
// Purpose  : AXI-style read-channel responder (slave end). It models a memory
//            target that answers reads out of order across IDs and in order
//            within an ID. The latency of each request depends only on its ID,
//            LAT_BASE + (2^ID_WIDTH-1-arid)*LAT_STEP cycles, so the response
//            order and data are fully predictable.
//            Response data = {id, tag}, where tag is the accept counter value
//            (mod 2^(DATA_WIDTH-ID_WIDTH)) at the time of acceptance.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            s_arid_i        - request ID
//            s_arvalid_i     - request valid
//            s_arready_o     - a slot is free (from current occupancy only)
//            s_rdata_o       - response data {id, tag}
//            s_rid_o         - response ID
//            s_rvalid_o      - response valid (registered output stage)
//            s_rready_i      - response accepted
//            s_rresp_o       - response status (only with RRESP_EN)
// Options  : `define RRESP_EN adds s_rresp_o and parameter ERR_ID. Requests
//            whose ID equals ERR_ID answer SLVERR (2'b10) with zero data.
// Revision : 1.0 - initial release
// ============================================================================
module ooo_read_responder #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 4,
  parameter int LAT_BASE   = 2,
  parameter int LAT_STEP   = 1
`ifdef RRESP_EN
  ,
  parameter int ERR_ID     = (1 << ID_WIDTH) - 1
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_arid_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [ID_WIDTH-1:0]   s_rid_o,
  output logic                  s_rvalid_o,
`ifdef RRESP_EN
  output logic [1:0]            s_rresp_o,
`endif
  input  logic                  s_rready_i
);

  localparam int TAG_W   = DATA_WIDTH - ID_WIDTH;
  localparam int LAT_MAX = LAT_BASE + ((1 << ID_WIDTH) - 1) * LAT_STEP;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Per-slot storage. occ = slot holds a request; iss = the request has
  // already been moved into the R output stage and waits for its handshake.
  logic [DEPTH-1:0]    occ_q, occ_d;
  logic [DEPTH-1:0]    iss_q, iss_d;
  logic [ID_WIDTH-1:0] id_q  [DEPTH];
  logic [ID_WIDTH-1:0] id_d  [DEPTH];
  logic [TAG_W-1:0]    tag_q [DEPTH];
  logic [TAG_W-1:0]    tag_d [DEPTH];
  // Age is the rank of the slot in accept order among occupied slots
  // (0 = oldest). Ranks above a departing slot shift down by one.
  logic [IDX_W-1:0]    age_q [DEPTH];
  logic [IDX_W-1:0]    age_d [DEPTH];
  // Remaining cycles until the slot becomes eligible (0 = eligible).
  logic [CNT_W-1:0]    cnt_q [DEPTH];
  logic [CNT_W-1:0]    cnt_d [DEPTH];

  logic [TAG_W-1:0]      acc_q, acc_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [IDX_W-1:0]      ridx_q, ridx_d;
  logic [1:0]            rresp_q, rresp_d;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] sel_age;
  logic [IDX_W:0]   occ_cnt;
  logic [IDX_W:0]   new_age;
  logic             hs_ar;
  logic             hs_r;
  logic             load;
  logic             sel_err;

  // Latency minus one: the slot is written on the handshake edge and must be
  // eligible one cycle before the edge that raises s_rvalid_o.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [ID_WIDTH-1:0] id);
    int l;
    l = LAT_BASE + (((1 << ID_WIDTH) - 1) - int'(id)) * LAT_STEP - 1;
    return l[CNT_W-1:0];
  endfunction

  // Lowest-index free slot and occupancy count.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    occ_cnt    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!occ_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      occ_cnt = occ_cnt + (IDX_W + 1)'(occ_q[i]);
    end
  end

  // Oldest eligible slot by accept order, excluding the one already staged.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ_q[i] && !iss_q[i] && (cnt_q[i] == '0) &&
          (!sel_found || (age_q[i] < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age_q[i];
      end
    end
  end

`ifdef RRESP_EN
  assign sel_err = (int'(id_q[sel_idx]) == ERR_ID);
`else
  assign sel_err = 1'b0;
`endif

  assign s_arready_o = free_found;
  assign hs_ar       = s_arvalid_i && free_found;
  assign hs_r        = rvalid_q && s_rready_i;
  assign load        = !rvalid_q || hs_r;
  // A request accepted while another departs ranks behind the survivors.
  assign new_age     = occ_cnt - (IDX_W + 1)'(hs_r);

  always_comb begin
    occ_d    = occ_q;
    iss_d    = iss_q;
    id_d     = id_q;
    tag_d    = tag_q;
    age_d    = age_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rid_d    = rid_q;
    ridx_d   = ridx_q;
    rresp_d  = rresp_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (occ_q[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
      if (hs_r && (age_q[i] > age_q[ridx_q])) begin
        age_d[i] = age_q[i] - 1'b1;
      end
    end

    if (hs_r) begin
      occ_d[ridx_q] = 1'b0;
      iss_d[ridx_q] = 1'b0;
    end

    if (load) begin
      if (sel_found) begin
        rvalid_d       = 1'b1;
        rid_d          = id_q[sel_idx];
        ridx_d         = sel_idx;
        iss_d[sel_idx] = 1'b1;
        rdata_d        = sel_err ? '0 : {id_q[sel_idx], tag_q[sel_idx]};
        rresp_d        = sel_err ? 2'b10 : 2'b00;
      end else begin
        rvalid_d = 1'b0;
      end
    end

    // The free slot is never the departing one, so no write conflict.
    if (hs_ar) begin
      occ_d[free_idx] = 1'b1;
      iss_d[free_idx] = 1'b0;
      id_d[free_idx]  = s_arid_i;
      tag_d[free_idx] = acc_q;
      age_d[free_idx] = new_age[IDX_W-1:0];
      cnt_d[free_idx] = lat_m1(s_arid_i);
      acc_d           = acc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= '0;
      iss_q    <= '0;
      acc_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      ridx_q   <= '0;
      rresp_q  <= 2'b00;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]  <= '0;
        tag_q[i] <= '0;
        age_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      occ_q    <= occ_d;
      iss_q    <= iss_d;
      acc_q    <= acc_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rid_q    <= rid_d;
      ridx_q   <= ridx_d;
      rresp_q  <= rresp_d;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]  <= id_d[i];
        tag_q[i] <= tag_d[i];
        age_q[i] <= age_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign s_rvalid_o = rvalid_q;
  assign s_rdata_o  = rdata_q;
  assign s_rid_o    = rid_q;
`ifdef RRESP_EN
  assign s_rresp_o  = rresp_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ooo_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ooo_read_responder
// Purpose  : Self-checking bench for ooo_read_responder. A request-level
//            reference model (queue of outstanding requests with their due
//            edge) is compared against the DUT every cycle; directed table
//            vectors and hand sequences cover latency, ordering, backpressure,
//            full occupancy and mid-operation reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ooo_read_responder;

  localparam int DW    = 8;
  localparam int IW    = 4;
  localparam int DEPTH = 4;
  localparam int LB    = 2;
  localparam int LS    = 1;
  localparam int TMOD  = 1 << (DW - IW);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] arid = '0;
  logic          arvalid = 1'b0;
  logic          rready = 1'b0;
  logic          s_arready_o;
  logic [DW-1:0] s_rdata_o;
  logic [IW-1:0] s_rid_o;
  logic          s_rvalid_o;
`ifdef RRESP_EN
  logic [1:0]    s_rresp_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ooo_read_responder #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH), .LAT_BASE(LB), .LAT_STEP(LS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_arid_i   (arid),
    .s_arvalid_i(arvalid),
    .s_arready_o(s_arready_o),
    .s_rdata_o  (s_rdata_o),
    .s_rid_o    (s_rid_o),
    .s_rvalid_o (s_rvalid_o),
`ifdef RRESP_EN
    .s_rresp_o  (s_rresp_o),
`endif
    .s_rready_i (rready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int id);
    return LB + ((1 << IW) - 1 - id) * LS;
  endfunction

  function automatic logic [DW-1:0] exp_data(input int id, input int tag);
`ifdef RRESP_EN
    if (id == (1 << IW) - 1) return '0;
`endif
    return DW'(id * TMOD + tag);
  endfunction

  // ---------------- request-level reference model ----------------
  typedef struct {int id; int tag; int due;} req_t;
  req_t q[$];
  int   e_num = 0;
  int   acc   = 0;
  bit   m_rv  = 1'b0;
  int   m_id  = 0;
  int   m_tag = 0;

  always @(posedge clk) begin
    bit hs_r, hs_ar;
    e_num++;
    if (rst) begin
      q.delete();
      m_rv = 1'b0; acc = 0;
    end else begin
      hs_r  = m_rv && rready;
      hs_ar = arvalid && ((q.size() + int'(m_rv)) < DEPTH);
      if (!m_rv || hs_r) begin
        int best;
        best = -1;
        // queue is in accept order, so the first due entry is the oldest
        for (int i = 0; i < q.size(); i++)
          if (best < 0 && q[i].due <= e_num) best = i;
        if (best >= 0) begin
          m_rv = 1'b1; m_id = q[best].id; m_tag = q[best].tag;
          q.delete(best);
        end else begin
          m_rv = 1'b0;
        end
      end
      if (hs_ar) begin
        q.push_back('{int'(arid), acc % TMOD, e_num + lat_of(int'(arid))});
        acc++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_arready", 32'(s_arready_o), 32'((q.size() + int'(m_rv)) < DEPTH));
      chk("m_rvalid", 32'(s_rvalid_o), 32'(m_rv));
      if (m_rv) begin
        chk("m_rdata", 32'(s_rdata_o), 32'(exp_data(m_id, m_tag)));
        chk("m_rid", 32'(s_rid_o), 32'(m_id));
`ifdef RRESP_EN
        chk("m_rresp", 32'(s_rresp_o), (m_id == (1 << IW) - 1) ? 32'd2 : 32'd0);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; arvalid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rv(input string nm, input int lim, output int n);
    n = 0;
    while (!s_rvalid_o && n < lim) begin
      tick();
      n++;
    end
    if (!s_rvalid_o) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {int id; int lat; logic [DW-1:0] data; logic [1:0] resp;} vec_t;
  vec_t tbl[4];

  initial begin
    int n, bad_v, bad_r;
    bit found;

    tbl[0] = '{3, 14, 8'h30, 2'b00};
`ifdef RRESP_EN
    tbl[1] = '{15, 2, 8'h00, 2'b10};
`else
    tbl[1] = '{15, 2, 8'hF0, 2'b00};
`endif
    tbl[2] = '{2, 15, 8'h20, 2'b00};
    tbl[3] = '{0, 17, 8'h00, 2'b00};

    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_rvalid", 32'(s_rvalid_o), 32'd0);
    chk("rst_rdata", 32'(s_rdata_o), 32'd0);
    chk("rst_rid", 32'(s_rid_o), 32'd0);
    chk("rst_arready", 32'(s_arready_o), 32'd1);

    // single request latency/data per ID
    for (int k = 0; k < 4; k++) begin
      do_reset();
      rready = 1'b1;
      arid = IW'(tbl[k].id); arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      wait_rv("tbl", 40, n);
      chk("tbl_lat", 32'(n), 32'(tbl[k].lat));
      chk("tbl_data", 32'(s_rdata_o), 32'(tbl[k].data));
      chk("tbl_rid", 32'(s_rid_o), 32'(tbl[k].id));
`ifdef RRESP_EN
      chk("tbl_rresp", 32'(s_rresp_o), 32'(tbl[k].resp));
`endif
      tick();
      chk("tbl_drop", 32'(s_rvalid_o), 32'd0);
    end

    // id 0 then id 15: 15 overtakes
    do_reset();
    rready = 1'b1;
    arvalid = 1'b1; arid = 4'd0; tick();
    arid = 4'd15; tick();
    arvalid = 1'b0;
    wait_rv("ooo1", 40, n);
    chk("ooo_first_rid", 32'(s_rid_o), 32'd15);
    chk("ooo_first_data", 32'(s_rdata_o), 32'(exp_data(15, 1)));
    tick();
    wait_rv("ooo2", 40, n);
    chk("ooo_second_rid", 32'(s_rid_o), 32'd0);
    chk("ooo_second_data", 32'(s_rdata_o), 32'h00);

    // two id 5 under long backpressure: in order, held stable
    do_reset();
    rready = 1'b0;
    arvalid = 1'b1; arid = 4'd5; tick(); tick();
    arvalid = 1'b0;
    repeat (30) tick();
    chk("bp_valid", 32'(s_rvalid_o), 32'd1);
    chk("bp_first", 32'(s_rdata_o), 32'h50);
    rready = 1'b1;
    tick();
    chk("bp_b2b_valid", 32'(s_rvalid_o), 32'd1);
    chk("bp_second", 32'(s_rdata_o), 32'h51);
    tick();
    chk("bp_drain", 32'(s_rvalid_o), 32'd0);

    // full occupancy: slot reuse only the cycle after the R handshake
    do_reset();
    rready = 1'b0;
    arvalid = 1'b1; arid = 4'd14;
    repeat (4) tick();
    chk("full_arready", 32'(s_arready_o), 32'd0);
    chk("full_rvalid", 32'(s_rvalid_o), 32'd1);
    chk("full_first", 32'(s_rdata_o), 32'hE0);
    rready = 1'b1;
    chk("full_hs_arready", 32'(s_arready_o), 32'd0);
    tick();
    chk("full_reuse_arready", 32'(s_arready_o), 32'd1);
    chk("full_b2b", 32'(s_rdata_o), 32'hE1);
    tick();
    arvalid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (s_rvalid_o && s_rdata_o == 8'hE4) found = 1'b1;
      tick();
    end
    chk("full_fifth_tag4", 32'(found), 32'd1);

    // reset mid-operation
    do_reset();
    rready = 1'b1;
    arvalid = 1'b1; arid = 4'd0;
    repeat (3) tick();
    arvalid = 1'b0;
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    bad_v = 0; bad_r = 0;
    repeat (40) begin
      tick();
      if (s_rvalid_o) bad_v++;
      if (!s_arready_o) bad_r++;
    end
    chk("mrst_no_rvalid", 32'(bad_v), 32'd0);
    chk("mrst_arready", 32'(bad_r), 32'd0);
    arvalid = 1'b1; arid = 4'd3; tick();
    arvalid = 1'b0;
    wait_rv("mrst", 40, n);
    chk("mrst_data", 32'(s_rdata_o), 32'h30);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      arvalid = 1'($urandom_range(1));
      arid    = IW'($urandom);
      rready  = ($urandom_range(9) < 7);
      rst     = ($urandom_range(499) == 0);
      tick();
    end
    rst = 1'b0; arvalid = 1'b0; rready = 1'b1;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ooo_read_responder.md
Name: ooo_read_responder

Overview:
- AXI-style read-channel responder (slave end) that sits downstream of the reorder buffer's master AR/R ports.
- It models a memory target that returns read data out of order across IDs and in order within an ID.
- Latency per request is a deterministic function of the ID, so benches can predict exact response order and data.
- It is used as the downstream model in reorder buffer system tests. It is also a standalone block.

Parameters:
- DATA_WIDTH, 8, R data width; must be greater than ID_WIDTH.
- ID_WIDTH, 4, AR/R ID width.
- DEPTH, 4, max outstanding requests (slot count); must be at least 2.
- LAT_BASE, 2, minimum latency in cycles; must be at least 2.
- LAT_STEP, 1, extra cycles per ID step below the max ID.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s_arid_i  in  ID_WIDTH  request ID.
- s_arvalid_i  in  1  request valid.
- s_arready_o  out  1  request accepted when high together with s_arvalid_i.
- s_rdata_o  out  DATA_WIDTH  response data.
- s_rid_o  out  ID_WIDTH  response ID.
- s_rvalid_o  out  1  response valid.
- s_rready_i  in  1  response accepted.

Behaviour:
- Reset (synchronous, rst=1 at clock edge):
  - All slots are freed; the accept counter and the age state are set to 0.
  - s_rvalid_o=0, s_rdata_o=0, s_rid_o=0; s_arready_o=1 from the first cycle after reset.
  - Reset mid-operation discards every outstanding request and any pending R beat. No stale response may appear after reset.
- AR channel:
  - s_arready_o = at least one slot free, computed from current occupancy only. It must not depend on s_arvalid_i or on an R handshake in the same cycle.
  - A slot freed by an R handshake in cycle N can be reused at the earliest in cycle N+1.
  - On AR handshake the block stores into the lowest-index free slot:
    - the ID;
    - tag = accept counter mod 2^(DATA_WIDTH-ID_WIDTH);
    - age stamp;
    - latency L = LAT_BASE + (2^ID_WIDTH-1-arid)*LAT_STEP.
  - The accept counter then increments and wraps naturally.
- Maturation: each occupied slot counts down once per cycle and becomes eligible when its count expires.
  - Unobstructed, s_rvalid_o for that request rises on the L-th rising edge after the AR handshake edge.
- R channel: single registered output stage.
  - When the stage is empty, or its beat is handshaking this cycle, it loads the oldest eligible slot by accept order, not by slot index. This lets back-to-back beats issue with no bubble.
  - Oldest-first selection guarantees in-order responses within an ID, even under backpressure.
  - s_rdata_o = {id, tag}: ID in the top ID_WIDTH bits, tag in the low bits.
  - While s_rvalid_o=1 and s_rready_i=0, s_rvalid_o, s_rdata_o and s_rid_o hold stable.
  - The slot frees when its beat handshakes.
- Simultaneous AR and R handshakes in one cycle are both honoured.
- Eligible slots waiting behind a stalled R stage keep their eligibility; no request is lost or duplicated.

Optional Feature:
- Macro: RRESP_EN.
- Defined:
  - Adds port s_rresp_o, out, 2 bits.
  - Adds parameter ERR_ID, default 2^ID_WIDTH-1.
  - Requests with arid==ERR_ID respond with s_rresp_o=2'b10 (SLVERR) and s_rdata_o=0.
  - All other requests respond with 2'b00 (OKAY) and normal data.
  - s_rresp_o resets to 0 and follows the same stability rule as s_rdata_o.
  - Timing and ordering are unchanged.
- Undefined: no s_rresp_o port and no ERR_ID; behaviour is exactly as above.

Test Plan (defaults):
- Single AR id=3 after reset:
  - L = 2 + 12*1 = 14.
  - s_rvalid_o rises 14 edges after the handshake with s_rid_o=3, s_rdata_o=8'h30.
  - With s_rready_i=1, s_rvalid_o drops the next cycle.
- AR id=0 (L=17), then id=15 (L=2) on the next cycle:
  - id 15 returns first with s_rdata_o=8'hF1.
  - id 0 follows with 8'h00.
- Two back-to-back AR id=5 with s_rready_i held low 30 cycles:
  - First beat is 8'h50, held stable; then 8'h51.
  - Never 8'h51 first.
- Four ARs accepted; fifth s_arvalid_i sees s_arready_o=0.
  - On the first R handshake cycle s_arready_o stays 0.
  - It rises the next cycle and the fifth AR is accepted with tag 4.
- Three outstanding requests, rst pulsed 1 cycle:
  - No s_rvalid_o for 40 cycles and s_arready_o=1.
  - A new AR id=3 returns 8'h30 (counter restarted).
- RRESP_EN defined, AR id=15:
  - s_rresp_o=2'b10, s_rdata_o=0.
  - AR id=2 returns s_rresp_o=2'b00, s_rdata_o=8'h21.
